// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// the iteration counter width helper.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_DIVU  = 2'b01,
      OP_MULT  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIN  = 2'b10
   } state_e;

   localparam int MDU_WIDTH_DEFAULT = 32;

   // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the MDU datapath: add-shift for multiply, restoring
// subtract-shift for divide. Purely combinational.
module mdu_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic                 is_div_i,
   input  logic [2*WIDTH-1:0]   acc_i,
   input  logic [WIDTH-1:0]     m_i,
   output logic [2*WIDTH-1:0]   acc_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] diff;
   logic             unused_diff;

   assign unused_diff = diff[WIDTH];

   always_comb begin
      sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, m_i};
      // Upper half is the partial remainder, lower half the remaining dividend bits.
      rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
      diff   = {1'b0, rem_sh} - {2'b00, m_i};
      acc_o  = '0;
      if (is_div_i) begin
         if (!diff[WIDTH+1]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
         end
      end else if (acc_i[0]) begin
         acc_o = {sum, acc_i[WIDTH-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Define MDU_SIGNED_EN to make op=10/11 signed (MULT/DIV); otherwise they act unsigned.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hilo_we,
   input  logic             hilo_sel,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // state  | meaning
   // S_IDLE | waiting for start; MTHI/MTLO accepted
   // S_RUN  | one iteration per cycle, WIDTH cycles; HI/LO written on the last one
   // S_FIN  | done pulse cycle; HI/LO already hold the result

   localparam int CNT_W = cnt_width(WIDTH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [WIDTH-1:0]   araw_q, araw_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dbz_q, dbz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               dbz_out_q, dbz_out_d;

   logic               sgn_op;
   logic               start_div;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc_nx;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_SIGNED_EN
   assign sgn_op = op[1];
`else
   logic unused_op1;
   assign unused_op1 = op[1];
   assign sgn_op     = 1'b0;
`endif

   assign start_div = (op == OP_DIVU) || (op == OP_DIV);
   assign a_neg     = sgn_op & operand_a[WIDTH-1];
   assign b_neg     = sgn_op & operand_b[WIDTH-1];
   assign a_mag     = a_neg ? ({WIDTH{1'b0}} - operand_a) : operand_a;
   assign b_mag     = b_neg ? ({WIDTH{1'b0}} - operand_b) : operand_b;

   mdu_iter_core #(.WIDTH(WIDTH)) u_core (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .m_i      (m_q),
      .acc_o    (acc_nx)
   );

   // Sign fix applied to the final iteration output so HI/LO are valid in S_FIN.
   assign prod_fix = neg_q     ? ({2*WIDTH{1'b0}} - acc_nx)            : acc_nx;
   assign quo_fix  = neg_q     ? ({WIDTH{1'b0}} - acc_nx[WIDTH-1:0])   : acc_nx[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? ({WIDTH{1'b0}} - acc_nx[2*WIDTH-1:WIDTH])
                               : acc_nx[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      m_d       = m_q;
      araw_d    = araw_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dbz_out_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (hilo_we) begin
               if (hilo_sel) hi_d = hilo_wdata;
               else          lo_d = hilo_wdata;
            end
            if (start) begin
               state_d   = S_RUN;
               cnt_d     = CNT_W'(WIDTH);
               is_div_d  = start_div;
               araw_d    = operand_a;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dbz_d     = start_div && (operand_b == '0);
               if (start_div) begin
                  acc_d = {{WIDTH{1'b0}}, a_mag};
                  m_d   = b_mag;
               end else begin
                  acc_d = {{WIDTH{1'b0}}, b_mag};
                  m_d   = a_mag;
               end
            end
         end
         S_RUN: begin
            acc_d = acc_nx;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d   = S_FIN;
               done_d    = 1'b1;
               dbz_out_d = dbz_q;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dbz_q) begin
                  hi_d = araw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         S_FIN: begin
            // busy is already low here, so MTHI/MTLO are honoured.
            if (hilo_we) begin
               if (hilo_sel) hi_d = hilo_wdata;
               else          lo_d = hilo_wdata;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         m_q       <= '0;
         araw_q    <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         m_q       <= m_d;
         araw_q    <= araw_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dbz_out_q <= dbz_out_d;
      end
   end

   assign busy        = (state_q == S_RUN);
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; signed expectations follow MDU_SIGNED_EN.
module tb_mult_div_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  operand_a, operand_b;
   logic          hilo_we, hilo_sel;
   logic [W-1:0]  hilo_wdata;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int errors = 0;
   int checks = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
      .hilo_we     (hilo_we),
      .hilo_sel    (hilo_sel),
      .hilo_wdata  (hilo_wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (cyc < 40 && done !== 1'b1) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int pulses;
      logic [W-1:0] exp_lo;

      reset = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
      hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      reset = 1'b1;
      tick();

      // MULTU max*max and latency
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("t1_busy", busy, 1'b1);
      wait_done(c);
      chk("t1_latency", c, 32);
      chk("t1_busy_fin", busy, 1'b0);
      chk("t1_hi", hi, 32'hFFFF_FFFE);
      chk("t1_lo", lo, 32'h0000_0001);
      tick();
      chk("t1_done_pulse", done, 1'b0);

      // DIVU and divide by zero
      issue(2'b01, 32'd100, 32'd7);
      wait_done(c);
      chk("t2_lo", lo, 32'd14);
      chk("t2_hi", hi, 32'd2);
      chk("t2_dbz", div_by_zero, 1'b0);
      tick();
      issue(2'b01, 32'd5, 32'd0);
      wait_done(c);
      chk("t2z_latency", c, 32);
      chk("t2z_dbz", div_by_zero, 1'b1);
      chk("t2z_lo", lo, 32'hFFFF_FFFF);
      chk("t2z_hi", hi, 32'd5);
      tick();
      chk("t2z_dbz_pulse", div_by_zero, 1'b0);

      // MULT / DIV
      issue(2'b10, 32'hFFFF_FFFD, 32'd5);
      wait_done(c);
`ifdef MDU_SIGNED_EN
      chk("t3_mult_hi", hi, 32'hFFFF_FFFF);
`else
      chk("t3_mult_hi", hi, 32'h0000_0004);
`endif
      chk("t3_mult_lo", lo, 32'hFFFF_FFF1);
      tick();
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_done(c);
`ifdef MDU_SIGNED_EN
      chk("t3_div_lo", lo, 32'hFFFF_FFFD);
      chk("t3_div_hi", hi, 32'hFFFF_FFFF);
`else
      chk("t3_div_lo", lo, 32'h7FFF_FFFC);
      chk("t3_div_hi", hi, 32'h0000_0001);
`endif
      tick();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(c);
`ifdef MDU_SIGNED_EN
      exp_lo = 32'h8000_0000;
      chk("t3_ovf_lo", lo, exp_lo);
      chk("t3_ovf_hi", hi, 32'h0);
`else
      exp_lo = 32'h0;
      chk("t3_ovf_lo", lo, exp_lo);
      chk("t3_ovf_hi", hi, 32'h8000_0000);
`endif
      tick();

      // start held high, operands changed, MTLO while busy
      start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4;
      tick();
      operand_a = 32'd100; operand_b = 32'd100;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 5) begin
            hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wdata = 32'h1234;
         end
         tick();
         if (i == 5) begin
            hilo_we = 1'b0;
            chk("t4_mtlo_busy", lo, exp_lo);
         end
         if (done === 1'b1) begin
            pulses++;
            start = 1'b0;
            chk("t4_hi", hi, 32'd0);
            chk("t4_lo", lo, 32'd12);
         end
      end
      start = 1'b0;
      chk("t4_pulses", pulses, 1);

      // MTHI and start in the same idle cycle
      hilo_we = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hAAAA;
      issue(2'b00, 32'd2, 32'd3);
      hilo_we = 1'b0;
      chk("t5_hi_written", hi, 32'hAAAA);
      chk("t5_busy", busy, 1'b1);
      wait_done(c);
      chk("t5_hi", hi, 32'd0);
      chk("t5_lo", lo, 32'd6);
      tick();

      // reset mid-operation, then a fresh op
      issue(2'b00, 32'd7, 32'd9);
      repeat (9) tick();
      chk("t6_busy_run", busy, 1'b1);
      reset = 1'b0;
      #1;
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_hi", hi, 32'd0);
      chk("t6_lo", lo, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      issue(2'b01, 32'd1000, 32'd7);
      wait_done(c);
      chk("t6_div_lo", lo, 32'd142);
      chk("t6_div_hi", hi, 32'd6);

      // start raised during FIN is ignored; accepted on the following edge
      start = 1'b1; op = 2'b00; operand_a = 32'd6; operand_b = 32'd7;
      tick();
      chk("t7_fin_ignore", busy, 1'b0);
      tick();
      start = 1'b0;
      chk("t7_accept", busy, 1'b1);
      wait_done(c);
      chk("t7_latency", c, 32);
      chk("t7_lo", lo, 32'd42);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
